// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-port data memory
// that has a same-cycle read path and a write strobe sampled on rising clk.
// Sub-word stores read the target word first, merge the new lane, then write
// the merged word back.
//
// Handshake: a request is taken on a rising edge where req_valid and req_ready
// are both high; req_ready is high only while idle, so at most one request is
// in flight. The response is a single-cycle resp_valid pulse with no
// backpressure. resp_rdata/resp_err hold their values until the next response.
module load_store_unit #(
  parameter int WORD_AW = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [WORD_AW+1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [WORD_AW-1:0] mem_addr,
  output logic               mem_MW,
  output logic [31:0]        mem_data_in,
  input  logic [31:0]        mem_data_out,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_req_err;
  logic [1:0]           r_size;
  logic                 r_signed;
  logic [1:0]           r_lane;
  logic [15:0]          r_wdata;
  logic [WORD_AW-1:0]   r_mem_addr;
  logic [31:0]          r_mem_data_in;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load_data;
  logic [31:0]          w_merged;

  assign w_accept    = req_valid & (r_state == S_IDLE);
  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign mem_MW      = (r_state == S_WRITE);
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign o_dbg_state = r_state;

  // Illegal size or an address not aligned to the access size.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: the path through the FSM is chosen once, at accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)             w_next = S_RESP;
          else if (!req_we)          w_next = S_LOAD;
          else if (req_size == 2'b10) w_next = S_WRITE;
          else                       w_next = S_RMW_READ;
        end
      end
      S_LOAD:     w_next = S_RESP;
      S_RMW_READ: w_next = S_WRITE;
      S_WRITE:    w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Load lane extraction and zero/sign extension from the live read data.
  always_comb begin
    w_byte      = mem_data_out[{r_lane, 3'b000} +: 8];
    w_half      = r_lane[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    w_load_data = mem_data_out;
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_data_out;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane.
  always_comb begin
    w_merged = mem_data_out;
    if (r_size == 2'b00) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // Request latch, memory drive and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_lane        <= 2'b00;
      r_wdata       <= 16'h0;
      r_mem_addr    <= '0;
      r_mem_data_in <= 32'h0;
      r_rdata       <= 32'h0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size     <= req_size;
        r_signed   <= req_signed;
        r_lane     <= req_addr[1:0];
        r_wdata    <= req_wdata[15:0];
        r_mem_addr <= req_addr[WORD_AW+1:2];
        if (req_we && !w_req_err) r_mem_data_in <= req_wdata;
        if (w_req_err) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == S_LOAD) begin
        r_rdata <= w_load_data;
        r_err   <= 1'b0;
      end
      if (r_state == S_RMW_READ) r_mem_data_in <= w_merged;
      if (r_state == S_WRITE) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort and
// back-to-back sequences, then random traffic against a word-array model.
module tb_load_store_unit;

  localparam int WORD_AW = 14;
  localparam int NWORDS  = 1 << WORD_AW;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [WORD_AW+1:0] req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic [WORD_AW-1:0] mem_addr;
  logic               mem_MW;
  logic [31:0]        mem_data_in;
  logic [31:0]        mem_data_out;
  logic [2:0]         dbg_state;

  logic [31:0] tb_mem  [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  logic [WORD_AW-1:0] wr_log[$];

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.WORD_AW(WORD_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_MW(mem_MW),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .o_dbg_state(dbg_state)
  );

  // Clock and memory environment.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_out = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_MW) begin
      tb_mem[mem_addr] <= mem_data_in;
      wr_log.push_back(mem_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: operates on whole words with plain arithmetic.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       output logic [31:0] er, output logic ee,
                       output int el, output int em);
    int nb;
    int sh;
    longint unsigned w, mask, val;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    if (nb == 0 || (int'(addr) % nb) != 0) begin
      er = 32'h0; ee = 1'b1; el = 1; em = 0;
      return;
    end
    w    = longint'(ref_mem[addr[15:2]]);
    sh   = 8 * (int'(addr) % 4);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (!we) begin
      val = (w >> sh) & mask;
      if (sgn && nb < 4 && ((val >> (8 * nb - 1)) & 64'd1) == 64'd1)
        val = val | (~mask & 64'hFFFF_FFFF);
      er = val[31:0]; ee = 1'b0; el = 2; em = 0;
    end else begin
      val = (w & ~(mask << sh)) | ((longint'(wdata) & mask) << sh);
      ref_mem[addr[15:2]] = val[31:0];
      er = 32'h0; ee = 1'b0; el = (nb == 4) ? 2 : 3; em = 1;
    end
  endtask

  // Driver: issue one request, wait for its response, report what was seen.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int mw, output logic [WORD_AW-1:0] maddr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_wait", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; mw = 0; rdata = 32'hx; err = 1'bx; maddr = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_MW) mw++;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err; maddr = mem_addr;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mw;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [31:0] rd, er;
    logic ee, e;
    logic [WORD_AW-1:0] ma;
    int lat, mw, el, em, acc_cyc, low_cyc, mw_cnt;

    for (int i = 0; i < NWORDS; i++) begin
      tb_mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    tb_mem[3] = 32'h80FF7F01;  ref_mem[3] = 32'h80FF7F01;
    tb_mem[4] = 32'h11223344;  ref_mem[4] = 32'h11223344;

    tbl[0]  = '{"lw_14",     1'b0, 2'd2, 1'b0, 16'h0014, 32'h0,        32'h00000005, 1'b0, 2, 0};
    tbl[1]  = '{"lb_0e",     1'b0, 2'd0, 1'b1, 16'h000E, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0};
    tbl[2]  = '{"lbu_0e",    1'b0, 2'd0, 1'b0, 16'h000E, 32'h0,        32'h000000FF, 1'b0, 2, 0};
    tbl[3]  = '{"lh_0e",     1'b0, 2'd1, 1'b1, 16'h000E, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0};
    tbl[4]  = '{"lbu_0c",    1'b0, 2'd0, 1'b0, 16'h000C, 32'h0,        32'h00000001, 1'b0, 2, 0};
    tbl[5]  = '{"sb_11",     1'b1, 2'd0, 1'b0, 16'h0011, 32'hAABBCCDD, 32'h00000000, 1'b0, 3, 1};
    tbl[6]  = '{"lw_10",     1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'h1122DD44, 1'b0, 2, 0};
    tbl[7]  = '{"lw_mis_06", 1'b0, 2'd2, 1'b0, 16'h0006, 32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[8]  = '{"ld_sz3",    1'b0, 2'd3, 1'b0, 16'h0008, 32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[9]  = '{"st_sz3",    1'b1, 2'd3, 1'b0, 16'h0008, 32'h12345678, 32'h00000000, 1'b1, 1, 0};
    tbl[10] = '{"sh_mis_21", 1'b1, 2'd1, 1'b0, 16'h0021, 32'h12345678, 32'h00000000, 1'b1, 1, 0};
    tbl[11] = '{"lhu_12",    1'b0, 2'd1, 1'b0, 16'h0012, 32'h0,        32'h00001122, 1'b0, 2, 0};
    tbl[12] = '{"sw_20",     1'b1, 2'd2, 1'b0, 16'h0020, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1};
    tbl[13] = '{"lw_20",     1'b0, 2'd2, 1'b0, 16'h0020, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    tbl[14] = '{"sh_22",     1'b1, 2'd1, 1'b0, 16'h0022, 32'hFFFF5678, 32'h00000000, 1'b0, 3, 1};
    tbl[15] = '{"lw_top",    1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0,        32'h00003FFF, 1'b0, 2, 0};
    tbl[16] = '{"lw_20b",    1'b0, 2'd2, 1'b0, 16'h0020, 32'h0,        32'h5678BEEF, 1'b0, 2, 0};

    // Reset and idle outputs.
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    reset = 1'b1;
    #1;
    chk("rst_ready",   {31'h0, req_ready},  32'h1);
    chk("rst_rvalid",  {31'h0, resp_valid}, 32'h0);
    chk("rst_mw",      {31'h0, mem_MW},     32'h0);
    chk("rst_err",     {31'h0, resp_err},   32'h0);
    chk("rst_rdata",   resp_rdata,          32'h0);
    chk("rst_maddr",   32'(mem_addr),       32'h0);
    chk("rst_mdin",    mem_data_in,         32'h0);
    chk("rst_state",   32'(dbg_state),      32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      issue(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, e, lat, mw, ma);
      model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, er, ee, el, em);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
      chk({tbl[i].name, "_err"}, {31'h0, e}, {31'h0, tbl[i].exp_err});
      chk({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].exp_lat));
      chk({tbl[i].name, "_mw"}, 32'(mw), 32'(tbl[i].exp_mw));
      chk({tbl[i].name, "_maddr"}, 32'(ma), 32'(tbl[i].addr[15:2]));
    end
    chk("mem_word4", tb_mem[4], 32'h1122DD44);
    chk("mem_word2", tb_mem[2], 32'h00000002);

    // Response registers hold after the pulse.
    issue(1'b0, 2'd2, 1'b0, 16'h0014, 32'h0, rd, e, lat, mw, ma);
    @(negedge clk);
    chk("hold_rvalid", {31'h0, resp_valid}, 32'h0);
    chk("hold_rdata", resp_rdata, 32'h00000005);

    // Reset during the read phase of a halfword store to word 7.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 16'h001C; req_wdata = 32'h0000ABCD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_rvalid", {31'h0, resp_valid}, 32'h0);
    mw_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_MW) mw_cnt++;
      chk("abort_ready_hi", {31'h0, req_ready}, 32'h1);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_MW || resp_valid) mw_cnt++;
    end
    chk("abort_no_write", 32'(mw_cnt), 32'h0);
    chk("abort_word7", tb_mem[7], 32'h00000007);
    issue(1'b0, 2'd2, 1'b0, 16'h001C, 32'h0, rd, e, lat, mw, ma);
    chk("after_abort_rdata", rd, 32'h00000007);
    chk("after_abort_lat", 32'(lat), 32'h2);

    // req_valid held high across two word stores.
    wr_log.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 16'h0030; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_addr = 16'h0034; req_wdata = 32'h0BADF00D;
    acc_cyc = 0; low_cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = c;
        break;
      end
      low_cyc++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    @(negedge clk);
    chk("b2b_accept_cyc", 32'(acc_cyc), 32'h3);
    chk("b2b_busy_cycles", 32'(low_cyc), 32'h2);
    chk("b2b_nwrites", 32'(wr_log.size()), 32'h2);
    if (wr_log.size() == 2) begin
      chk("b2b_first_addr", 32'(wr_log[0]), 32'd12);
      chk("b2b_second_addr", 32'(wr_log[1]), 32'd13);
    end
    chk("b2b_word12", tb_mem[12], 32'hCAFEF00D);
    chk("b2b_word13", tb_mem[13], 32'h0BADF00D);
    ref_mem[12] = 32'hCAFEF00D;
    ref_mem[13] = 32'h0BADF00D;

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      logic        r_we, r_sgn;
      logic [1:0]  r_size;
      logic [15:0] r_addr;
      logic [31:0] r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) r_addr = 16'hFF00 | 16'($urandom_range(0, 255));
      r_wd   = $urandom;
      model(r_we, r_size, r_sgn, r_addr, r_wd, er, ee, el, em);
      issue(r_we, r_size, r_sgn, r_addr, r_wd, rd, e, lat, mw, ma);
      chk($sformatf("rnd%0d_rdata", n), rd, er);
      chk($sformatf("rnd%0d_err", n), {31'h0, e}, {31'h0, ee});
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(el));
      chk($sformatf("rnd%0d_mw", n), 32'(mw), 32'(em));
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final_word%0d", i), tb_mem[i], ref_mem[i]);
    for (int i = NWORDS - 64; i < NWORDS; i++) chk($sformatf("final_word%0d", i), tb_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORD_AW, 14, word-address width of the attached data memory (byte address width = WORD_AW+2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  in  WORD_AW+2  byte address.
REQ-010 req_wdata  in  32  store data; byte/halfword stores use the low 8/16 bits.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-013 resp_err  out  1  qualified by resp_valid: misaligned address or illegal size.
REQ-014 mem_addr  out  WORD_AW  word address to the data memory.
REQ-015 mem_MW  out  1  memory write enable, sampled by the memory on rising clk.
REQ-016 mem_data_in  out  32  write data to the memory.
REQ-017 mem_data_out  in  32  combinational (same-cycle) read data from the memory.

Function
REQ-018 States: IDLE, LOAD, RMW_READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 Accept = req_valid & req_ready on a rising edge; latch we, size, signed, addr, wdata.
REQ-020 Error at accept (size=11, halfword with addr[0]=1, word with addr[1:0]!=0): IDLE->RESP, resp_err=1, resp_rdata=0, no memory access.
REQ-021 Legal load: IDLE->LOAD->RESP; resp_rdata registered from mem_data_out at the end of LOAD.
REQ-022 Legal word store: IDLE->WRITE->RESP; mem_data_in = latched wdata.
REQ-023 Legal byte/halfword store: IDLE->RMW_READ->WRITE->RESP; mem_data_out captured at the end of RMW_READ, target lane replaced, merged word driven in WRITE.
REQ-024 mem_MW=1 only in WRITE, exactly one cycle per store; 0 in all other states.
REQ-025 mem_addr = latched addr[WORD_AW+1:2] registered at accept; holds until the next accept.
REQ-026 Lanes little-endian: byte k = bits 8k+7:8k with k=addr[1:0]; halfword = bits 31:16 if addr[1]=1, else bits 15:0.
REQ-027 Loads: extract lane, then zero- or sign-extend to 32 bits per req_signed; word loads ignore req_signed.
REQ-028 RESP lasts exactly one cycle (resp_valid=1), then IDLE; no response backpressure.
REQ-029 resp_rdata/resp_err registered; they hold their values until the next RESP.
REQ-030 Latency from the accept edge to resp_valid high: error 1 cycle; load and word store 2 cycles; byte/halfword store 3 cycles.
REQ-031 req_valid held high during a busy period is ignored; the next request is accepted in the first IDLE cycle after RESP.
REQ-032 Address wrap: the top byte address maps to word 2^WORD_AW-1; there is no out-of-range error.

Reset
REQ-033 On reset assertion, asynchronously: state=IDLE, mem_MW=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_data_in=0, req_ready=1.
REQ-034 Reset mid-operation aborts the operation: no write issued, no response produced; the next request after deassertion is handled normally.

Verification
REQ-035 Bench memory model preloaded with word i = i; word load addr 0x0014 -> mem_addr=5, resp_rdata=0x00000005, resp_valid 2 cycles after accept, resp_err=0.
REQ-036 Word 3=0x80FF7F01: signed byte load 0x000E -> 0xFFFFFFFF; unsigned byte load 0x000E -> 0x000000FF; signed halfword load 0x000E -> 0xFFFF80FF; unsigned byte load 0x000C -> 0x00000001.
REQ-037 Word 4=0x11223344: byte store addr 0x0011 wdata 0xAABBCCDD -> word 4 becomes 0x1122DD44; mem_MW high exactly 1 cycle; resp_valid 3 cycles after accept.
REQ-038 Word load addr 0x0006, and any req_size=11 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, mem_MW never high.
REQ-039 Assert reset during RMW_READ of a halfword store to word 7 -> mem_MW never asserts, word 7 stays 7, req_ready=1 while reset is high.
REQ-040 req_valid held high across two word stores -> req_ready low from accept through RESP; second accept occurs 3 cycles after the first; both words written in order.
